// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- pipeline sequencing controller for the 5-stage core.
//
// Merges trap requests from WB, taken-branch redirects from EX and the
// hazard/busy indications from ID/EX/MEM into per-stage stall and flush
// controls plus a PC redirect toward IF. The redirect is handshaken with
// IF's request-ready. If IF is not ready, the target is parked in a pending
// register and re-presented every cycle until IF accepts it. After reset the
// controller issues a boot redirect to RESET_PC. Two debug counters track
// accepted traps and stalled-fetch cycles.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   wb_trap_i/wb_trap_pc_i    WB trap request and handler/mepc target
//   ex_br_taken_i/_target_i   EX taken branch/jump and its target
//   id_load_use_i             ID load-use hazard
//   ex_mdu_busy_i             multi-cycle mul/div still running in EX
//   mem_busy_i                LSU access still running in MEM
//   if_req_ready_i            IF accepts a redirect this cycle
//   pc_redirect_o/_pc_o       redirect request and address toward IF
//   stall_*_o                 hold the stage's input pipeline register
//   flush_*_o                 load a bubble into the stage's input register
//   ctrl_state_o              FSM state (debug)
//   trap_cnt_o                accepted traps, wraps
//   stall_cnt_o               cycles with stall_if_o=1, saturates
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            wb_trap_i,
    input  logic [XLEN-1:0] wb_trap_pc_i,
    input  logic            ex_br_taken_i,
    input  logic [XLEN-1:0] ex_br_target_i,
    input  logic            id_load_use_i,
    input  logic            ex_mdu_busy_i,
    input  logic            mem_busy_i,
    input  logic            if_req_ready_i,
    output logic            pc_redirect_o,
    output logic [XLEN-1:0] pc_redirect_pc_o,
    output logic            stall_if_o,
    output logic            stall_id_o,
    output logic            stall_ex_o,
    output logic            stall_mem_o,
    output logic            flush_id_o,
    output logic            flush_ex_o,
    output logic            flush_mem_o,
    output logic            flush_wb_o,
    output logic [1:0]      ctrl_state_o,
    output logic [31:0]     trap_cnt_o,
    output logic [15:0]     stall_cnt_o
);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        PEND    = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pend_pc;
    logic [31:0]     r_trap_cnt;
    logic [15:0]     r_stall_cnt;

    state_t          w_next_state;
    logic [XLEN-1:0] w_next_pend_pc;
    logic            w_trap_acc;
    logic            w_redir;
    logic [XLEN-1:0] w_redir_pc;
    // Raw stage controls before flush-over-stall resolution.
    // w_stall_raw = {IF, ID, EX, MEM}, w_flush = {ID, EX, MEM, WB}.
    logic [3:0]      w_stall_raw;
    logic [3:0]      w_flush;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case/if tree leaves one unassigned and infers a latch.
        w_next_state   = r_state;
        w_next_pend_pc = r_pend_pc;
        w_trap_acc     = 1'b0;
        w_redir        = 1'b0;
        w_redir_pc     = '0;
        w_stall_raw    = 4'b0000;
        w_flush        = 4'b0000;

        case (r_state)
            RUN: begin
                if (wb_trap_i) begin
                    // Trap wins over everything, including a same-cycle branch.
                    w_redir    = 1'b1;
                    w_redir_pc = wb_trap_pc_i;
                    w_flush    = 4'b1111;
                    w_trap_acc = 1'b1;
                end else if (ex_br_taken_i && !mem_busy_i) begin
                    w_redir    = 1'b1;
                    w_redir_pc = ex_br_target_i;
                    w_flush    = 4'b1100;
                end else if (mem_busy_i) begin
                    // A taken branch under mem_busy is held in EX by this stall
                    // and redirects once MEM frees up.
                    w_stall_raw = 4'b1111;
                    w_flush     = 4'b0001;
                end else if (ex_mdu_busy_i) begin
                    w_stall_raw = 4'b1110;
                    w_flush     = 4'b0010;
                end else if (id_load_use_i) begin
                    w_stall_raw = 4'b1100;
                    w_flush     = 4'b0100;
                end

                if (w_redir && !if_req_ready_i) begin
                    w_next_state   = PEND;
                    w_next_pend_pc = w_redir_pc;
                end
            end

            PEND: begin
                // Fetch is frozen and ID is drained until IF takes the target.
                w_redir     = 1'b1;
                w_redir_pc  = r_pend_pc;
                w_stall_raw = 4'b1000;
                w_flush     = 4'b1000;
                if (wb_trap_i) begin
                    w_redir_pc     = wb_trap_pc_i;
                    w_next_pend_pc = wb_trap_pc_i;
                    w_flush        = 4'b1111;
                    w_trap_acc     = 1'b1;
                end else if (mem_busy_i) begin
                    // Only the EX/MEM/WB part of the RUN pattern applies here.
                    w_stall_raw = 4'b1011;
                    w_flush     = 4'b1001;
                end else if (ex_mdu_busy_i) begin
                    w_stall_raw = 4'b1010;
                    w_flush     = 4'b1010;
                end

                if (if_req_ready_i) begin
                    w_next_state = RUN;
                end
            end

            default: begin
                // BOOT, and the illegal encoding which recovers through BOOT.
                w_redir      = 1'b1;
                w_redir_pc   = RESET_PC;
                w_flush      = 4'b1111;
                w_next_state = (r_state == BOOT && if_req_ready_i) ? RUN : BOOT;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= BOOT;
            r_pend_pc   <= RESET_PC;
            r_trap_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_state   <= w_next_state;
            r_pend_pc <= w_next_pend_pc;
            if (w_trap_acc) begin
                r_trap_cnt <= r_trap_cnt + 32'd1;
            end
            if (stall_if_o && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign pc_redirect_o    = w_redir;
    assign pc_redirect_pc_o = w_redir_pc;

    // A stage that is being flushed must not also hold its register.
    assign stall_if_o  = w_stall_raw[3];
    assign stall_id_o  = w_stall_raw[2] & ~w_flush[3];
    assign stall_ex_o  = w_stall_raw[1] & ~w_flush[2];
    assign stall_mem_o = w_stall_raw[0] & ~w_flush[1];

    assign flush_id_o  = w_flush[3];
    assign flush_ex_o  = w_flush[2];
    assign flush_mem_o = w_flush[1];
    assign flush_wb_o  = w_flush[0];

    assign ctrl_state_o = r_state;
    assign trap_cnt_o   = r_trap_cnt;
    assign stall_cnt_o  = r_stall_cnt;

endmodule
